// File: rtl/ram_port_arbiter_if.sv
// Requester, response and RAM-side signals of the two-port RAM arbiter.
// slave = arbiter side, master = requesters plus RAM model.
interface ram_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  req0_valid, req0_ready, req0_we, req0_last;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req1_valid, req1_ready, req1_we, req1_last;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  rsp0_valid, rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp0_rdata, rsp1_rdata;
    logic                  ram_en, ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din, ram_dout;

    modport slave (
        input  req0_valid, req0_we, req0_last, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_last, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        output ram_en, ram_we, ram_addr, ram_din,
        input  ram_dout
    );

    modport master (
        output req0_valid, req0_we, req0_last, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_last, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        input  ram_en, ram_we, ram_addr, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two burst requesters.
// Grant is locked from the first to the last beat of a burst; reads answer one cycle later.
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input logic            clk,
    input logic            rst,
    ram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t                     state, state_nxt;
    logic                       prio, prio_nxt;
    logic [1:0]                 rd_pend, rd_pend_nxt;
    logic [1:0]                 vld, we, last, rdy;
    logic [1:0][ADDR_WIDTH-1:0] addr;
    logic [1:0][DATA_WIDTH-1:0] wdata;
    logic                       acc, sel;
    logic [1:0]                 rsp_vld;

    assign vld   = {bus.req1_valid, bus.req0_valid};
    assign we    = {bus.req1_we,    bus.req0_we};
    assign last  = {bus.req1_last,  bus.req0_last};
    assign addr  = {bus.req1_addr,  bus.req0_addr};
    assign wdata = {bus.req1_wdata, bus.req0_wdata};

    assign bus.req0_ready = rdy[0];
    assign bus.req1_ready = rdy[1];

    // Response of a read accepted just before a reset cycle is dropped.
    assign rsp_vld        = rst ? 2'b00 : rd_pend;
    assign bus.rsp0_valid = rsp_vld[0];
    assign bus.rsp1_valid = rsp_vld[1];
    assign bus.rsp0_rdata = rsp_vld[0] ? bus.ram_dout : '0;
    assign bus.rsp1_rdata = rsp_vld[1] ? bus.ram_dout : '0;

    always_comb begin
        rdy          = 2'b00;
        state_nxt    = state;
        prio_nxt     = prio;
        rd_pend_nxt  = 2'b00;
        bus.ram_en   = 1'b0;
        bus.ram_we   = 1'b0;
        bus.ram_addr = '0;
        bus.ram_din  = '0;
        if (!rst) begin
            case (state)
                IDLE:    rdy = (&vld) ? (prio ? 2'b10 : 2'b01) : vld;
                OWN0:    rdy = {1'b0, vld[0]};
                OWN1:    rdy = {vld[1], 1'b0};
                default: rdy = 2'b00;
            endcase
        end
        acc = |rdy;
        sel = rdy[1];
        if (acc) begin
            bus.ram_en       = 1'b1;
            bus.ram_we       = we[sel];
            bus.ram_addr     = addr[sel];
            bus.ram_din      = wdata[sel];
            rd_pend_nxt[sel] = ~we[sel];
            if (last[sel]) begin
                state_nxt = IDLE;
                prio_nxt  = ~sel;
            end else begin
                state_nxt = sel ? OWN1 : OWN0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            prio    <= 1'b0;
            rd_pend <= 2'b00;
        end else begin
            state   <= state_nxt;
            prio    <= prio_nxt;
            rd_pend <= rd_pend_nxt;
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus random traffic checked
// against a grant/ownership model and a shadow memory.
module tb_ram_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Single-port RAM: registered read, read-first on write.
    logic [DW-1:0] ram [1024] = '{default: '0};
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_din;
            bus.ram_dout <= ram[bus.ram_addr];
        end
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [1024] = '{default: '0};
    int            m_owner = -1;
    bit            m_prio  = 1'b0;
    logic [1:0]    exp_rv  = 2'b00;
    logic [DW-1:0] exp_rd  = '0;

    wire [2+2+AW+DW-1:0] obs_bus = {bus.req1_ready, bus.req0_ready, bus.ram_en, bus.ram_we,
                                    bus.ram_addr, bus.ram_din};
    wire [2+2*DW-1:0]    obs_rsp = {bus.rsp1_valid, bus.rsp0_valid, bus.rsp1_rdata, bus.rsp0_rdata};

    function automatic logic in_v(int n);        return n ? bus.req1_valid : bus.req0_valid; endfunction
    function automatic logic in_we(int n);       return n ? bus.req1_we    : bus.req0_we;    endfunction
    function automatic logic in_last(int n);     return n ? bus.req1_last  : bus.req0_last;  endfunction
    function automatic logic [AW-1:0] in_a(int n); return n ? bus.req1_addr  : bus.req0_addr;  endfunction
    function automatic logic [DW-1:0] in_d(int n); return n ? bus.req1_wdata : bus.req0_wdata; endfunction

    function automatic logic [1:0] m_ready();
        logic [1:0] v;
        v = {in_v(1), in_v(0)};
        if (rst) return 2'b00;
        if (m_owner == 0) return {1'b0, v[0]};
        if (m_owner == 1) return {v[1], 1'b0};
        if (v == 2'b11) return m_prio ? 2'b10 : 2'b01;
        return v;
    endfunction

    function automatic logic [2+2+AW+DW-1:0] m_bus();
        logic [1:0] r;
        int n;
        r = m_ready();
        n = r[1] ? 1 : 0;
        if (r == 2'b00) return '0;
        return {r, 1'b1, in_we(n), in_a(n), in_d(n)};
    endfunction

    function automatic logic [2+2*DW-1:0] m_rsp();
        logic [1:0] ev;
        ev = rst ? 2'b00 : exp_rv;
        return {ev, ev[1] ? exp_rd : {DW{1'b0}}, ev[0] ? exp_rd : {DW{1'b0}}};
    endfunction

    // Advance the model across the coming edge, then step to just after it.
    task automatic next();
        logic [1:0] r;
        int n;
        r = m_ready();
        exp_rv = 2'b00;
        if (rst) begin
            m_owner = -1;
            m_prio  = 1'b0;
        end else if (r != 2'b00) begin
            n = r[1] ? 1 : 0;
            if (!in_we(n)) begin
                exp_rv[n] = 1'b1;
                exp_rd    = ref_mem[in_a(n)];
            end else begin
                ref_mem[in_a(n)] = in_d(n);
            end
            if (in_last(n)) begin
                m_owner = -1;
                m_prio  = (n == 0);
            end else begin
                m_owner = n;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input bit v, input bit we, input bit last,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_we = we; bus.req0_last = last;
            bus.req0_addr = a;  bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v; bus.req1_we = we; bus.req1_last = last;
            bus.req1_addr = a;  bus.req1_wdata = d;
        end
    endtask

    task automatic test_reset();
        set_req(0, 1, 0, 0, 10'h005, '0);
        set_req(1, 1, 0, 0, 10'h006, '0);
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if ({obs_bus, bus.rsp1_valid, bus.rsp0_valid} !== '0) begin
                errors++; $display("FAIL reset_outputs got=%h required=0", {obs_bus, bus.rsp1_valid, bus.rsp0_valid});
            end
            checks++;
            if (obs_rsp !== m_rsp()) begin
                errors++; $display("FAIL reset_rsp got=%h required=%h", obs_rsp, m_rsp());
            end
            next();
        end
        rst = 1'b0;
        set_req(0, 1, 0, 1, 10'h005, '0);
        set_req(1, 1, 0, 1, 10'h006, '0);
        #1;
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
            errors++; $display("FAIL reset_first_grant got=%b required=01", {bus.req1_ready, bus.req0_ready});
        end
        next();
        set_req(0, 0, 0, 0, '0, '0);
        set_req(1, 0, 0, 0, '0, '0);
        #1;
        checks++;
        if (obs_rsp !== m_rsp()) begin
            errors++; $display("FAIL reset_release_rsp got=%h required=%h", obs_rsp, m_rsp());
        end
        next();
    endtask

    task automatic test_single_read();
        for (int c = 0; c < 3; c++) begin
            if (c == 0)      set_req(0, 1, 1, 1, 10'h010, 32'hDEADBEEF);
            else if (c == 1) set_req(0, 1, 0, 1, 10'h010, '0);
            else             set_req(0, 0, 0, 0, '0, '0);
            #1;
            checks++;
            if (obs_bus !== m_bus()) begin
                errors++; $display("FAIL single_bus c=%0d got=%h required=%h", c, obs_bus, m_bus());
            end
            if (c == 2) begin
                checks++;
                if (!(bus.rsp0_valid === 1'b1 && bus.rsp1_valid === 1'b0 && bus.rsp0_rdata === 32'hDEADBEEF)) begin
                    errors++; $display("FAIL single_rsp got v0=%b v1=%b d=%h required v0=1 v1=0 d=deadbeef",
                                       bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_rdata);
                end
            end
            next();
        end
    endtask

    task automatic test_burst_lock();
        logic [DW-1:0] bd [4];
        int b = 0;
        bit r1_done = 1'b0;
        bit got_rsp = 1'b0;
        foreach (bd[i]) bd[i] = $urandom;
        for (int c = 0; c < 7; c++) begin
            if (b < 4) set_req(0, 1, 1, b == 3, AW'(32'h20 + b), bd[b]);
            else       set_req(0, 0, 0, 0, '0, '0);
            set_req(1, c >= 1 && !r1_done, 0, 1, 10'h022, '0);
            #1;
            checks++;
            if (obs_bus !== m_bus()) begin
                errors++; $display("FAIL burst_bus c=%0d got=%h required=%h", c, obs_bus, m_bus());
            end
            checks++;
            if (obs_rsp !== m_rsp()) begin
                errors++; $display("FAIL burst_rsp c=%0d got=%h required=%h", c, obs_rsp, m_rsp());
            end
            if (c >= 1 && !r1_done) begin
                checks++;
                if (bus.req1_ready !== (b == 4)) begin
                    errors++; $display("FAIL burst_lock_ready1 c=%0d got=%b required=%b", c, bus.req1_ready, b == 4);
                end
            end
            if (bus.rsp1_valid === 1'b1) begin
                got_rsp = 1'b1;
                checks++;
                if (bus.rsp1_rdata !== bd[2]) begin
                    errors++; $display("FAIL burst_rdata got=%h required=%h", bus.rsp1_rdata, bd[2]);
                end
            end
            if (bus.req0_valid && bus.req0_ready) b++;
            if (bus.req1_valid && bus.req1_ready) r1_done = 1'b1;
            next();
        end
        checks++;
        if (!got_rsp) begin
            errors++; $display("FAIL burst_rsp_seen got=0 required=1");
        end
    endtask

    task automatic test_round_robin();
        int a0 = 0, a1 = 0, v0 = 0, v1 = 0;
        for (int c = 0; c < 11; c++) begin
            set_req(0, c < 10, 0, 1, AW'($urandom_range(32, 35)), '0);
            set_req(1, c < 10, 0, 1, AW'($urandom_range(32, 35)), '0);
            #1;
            checks++;
            if (obs_bus !== m_bus()) begin
                errors++; $display("FAIL rr_bus c=%0d got=%h required=%h", c, obs_bus, m_bus());
            end
            checks++;
            if (obs_rsp !== m_rsp()) begin
                errors++; $display("FAIL rr_rsp c=%0d got=%h required=%h", c, obs_rsp, m_rsp());
            end
            if (c < 10) begin
                checks++;
                if ({bus.req1_ready, bus.req0_ready} !== ((c % 2) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL rr_alternate c=%0d got=%b required=%b", c,
                                       {bus.req1_ready, bus.req0_ready}, (c % 2) ? 2'b10 : 2'b01);
                end
            end
            a0 += int'(bus.req0_valid & bus.req0_ready);
            a1 += int'(bus.req1_valid & bus.req1_ready);
            v0 += int'(bus.rsp0_valid);
            v1 += int'(bus.rsp1_valid);
            next();
        end
        checks++;
        if (a0 != 5 || a1 != 5 || v0 != 5 || v1 != 5) begin
            errors++; $display("FAIL rr_counts got a0=%0d a1=%0d r0=%0d r1=%0d required 5 each", a0, a1, v0, v1);
        end
    endtask

    task automatic test_burst_gap();
        for (int c = 0; c < 7; c++) begin
            case (c)
                0:       set_req(1, 1, 0, 0, 10'h020, '0);
                1:       set_req(1, 1, 0, 0, 10'h021, '0);
                4:       set_req(1, 1, 0, 1, 10'h022, '0);
                default: set_req(1, 0, 0, 0, '0, '0);
            endcase
            set_req(0, c >= 1 && c <= 5, 0, 1, 10'h021, '0);
            #1;
            checks++;
            if (obs_bus !== m_bus()) begin
                errors++; $display("FAIL gap_bus c=%0d got=%h required=%h", c, obs_bus, m_bus());
            end
            checks++;
            if (obs_rsp !== m_rsp()) begin
                errors++; $display("FAIL gap_rsp c=%0d got=%h required=%h", c, obs_rsp, m_rsp());
            end
            if (c == 2 || c == 3) begin
                checks++;
                if (bus.ram_en !== 1'b0 || bus.req0_ready !== 1'b0) begin
                    errors++; $display("FAIL gap_hold c=%0d got en=%b rdy0=%b required 0 0", c, bus.ram_en, bus.req0_ready);
                end
            end
            if (c == 5) begin
                checks++;
                if (bus.req0_ready !== 1'b1) begin
                    errors++; $display("FAIL gap_handover got=%b required=1", bus.req0_ready);
                end
            end
            next();
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int c = 0; c < 6; c++) begin
            rst = (c == 2);
            case (c)
                0, 1, 2: set_req(0, 1, 0, 0, AW'(32'h20 + c), '0);
                4:       set_req(0, 1, 0, 1, 10'h023, '0);
                default: set_req(0, 0, 0, 0, '0, '0);
            endcase
            set_req(1, c >= 2 && c <= 4, 0, 1, 10'h023, '0);
            #1;
            checks++;
            if (obs_bus !== m_bus()) begin
                errors++; $display("FAIL rstmid_bus c=%0d got=%h required=%h", c, obs_bus, m_bus());
            end
            checks++;
            if (obs_rsp !== m_rsp()) begin
                errors++; $display("FAIL rstmid_rsp c=%0d got=%h required=%h", c, obs_rsp, m_rsp());
            end
            if (c == 2) begin
                checks++;
                if ({bus.req1_ready, bus.req0_ready, bus.ram_en, bus.rsp0_valid} !== 4'b0000) begin
                    errors++; $display("FAIL rstmid_quiet got=%b required=0000",
                                       {bus.req1_ready, bus.req0_ready, bus.ram_en, bus.rsp0_valid});
                end
            end
            if (c == 3) begin
                checks++;
                if (bus.req1_ready !== 1'b1) begin
                    errors++; $display("FAIL rstmid_grant1 got=%b required=1", bus.req1_ready);
                end
            end
            next();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            for (int n = 0; n < 2; n++)
                set_req(n, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
                        AW'($urandom_range(0, 15)), $urandom);
            #1;
            checks++;
            if (obs_bus !== m_bus()) begin
                errors++; $display("FAIL rand_bus c=%0d got=%h required=%h", c, obs_bus, m_bus());
            end
            checks++;
            if (obs_rsp !== m_rsp()) begin
                errors++; $display("FAIL rand_rsp c=%0d got=%h required=%h", c, obs_rsp, m_rsp());
            end
            next();
        end
        rst = 1'b0;
        set_req(0, 0, 0, 0, '0, '0);
        set_req(1, 0, 0, 0, '0, '0);
        #1;
        checks++;
        if (obs_rsp !== m_rsp()) begin
            errors++; $display("FAIL rand_tail_rsp got=%h required=%h", obs_rsp, m_rsp());
        end
        next();
    endtask

    initial begin
        set_req(0, 0, 0, 0, '0, '0);
        set_req(1, 0, 0, 0, '0, '0);
        @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_burst_lock();
        test_round_robin();
        test_burst_gap();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter that shares one single-port RAM (1-cycle registered read, read-first on write) between two DMA-side masters, e.g. the MM2S read engine and the S2MM write engine. Each requester issues single-beat or multi-beat bursts over a valid/ready handshake. Grants are round-robin and locked for the whole burst. Read data returns on a per-requester response strobe exactly one cycle after acceptance.

## Interface
- DATA_WIDTH, 32, RAM word width
- ADDR_WIDTH, 10, RAM address width
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  requester has a beat pending
- req0_ready / req1_ready  out  1  beat accepted this cycle when valid&ready
- req0_we / req1_we  in  1  1 = write beat, 0 = read beat
- req0_last / req1_last  in  1  final beat of burst; releases grant
- req0_addr / req1_addr  in  ADDR_WIDTH  word address
- req0_wdata / req1_wdata  in  DATA_WIDTH  write data
- rsp0_valid / rsp1_valid  out  1  read data valid (no backpressure)
- rsp0_rdata / rsp1_rdata  out  DATA_WIDTH  read data
- ram_en  out  1  to RAM en
- ram_we  out  1  to RAM we
- ram_addr  out  ADDR_WIDTH  to RAM addr
- ram_din  out  DATA_WIDTH  to RAM din
- ram_dout  in  DATA_WIDTH  from RAM dout

## Operation
- States: IDLE, OWN0, OWN1. Priority pointer `prio` (0 or 1) names the favoured requester in IDLE.
- IDLE behaviour:
  - If exactly one reqN_valid is set, reqN_ready=1.
  - If both are set, only req[prio] gets ready.
  - Accepted beat with last=0 → OWNn.
  - Accepted beat with last=1 → stay IDLE, prio ← other requester.
- OWNn behaviour:
  - reqN_ready = reqN_valid. The other requester's ready=0 regardless of its valid.
  - Accepted beat with last=1 → IDLE, prio ← other requester.
  - reqN_valid=0 → no RAM access; stay OWNn (burst gaps allowed, grant held).
- Ready may depend combinationally on valid. Requesters must not make valid depend on ready.
- RAM drive (combinational from the accepted beat):
  - ram_en = accept.
  - ram_we, ram_addr, ram_din are muxed from the accepted requester.
  - When idle, ram_en=0, ram_we=0, and addr/din are 0.
- Responses:
  - A registered flag `rd_pend[n]` is set for an accepted read by requester n (we=0) and cleared otherwise.
  - rspN_valid = rd_pend[n].
  - rspN_rdata = ram_dout when rd_pend[n], else 0.
  - Write beats produce no response.
- At most one rspN_valid is high per cycle.
- Read-after-write to the same address in consecutive beats returns the new data. The RAM commits the write before the next read edge.
- Reset:
  - While rst=1: state ← IDLE, prio ← 0, rd_pend ← 0.
  - Both ready outputs and ram_en are forced 0 during the rst cycle.
  - A burst in flight is abandoned; its owner restarts it after reset.
  - RAM contents are untouched.
- Reset output values: all outputs 0.

## Timing
- Accept-to-RAM: same cycle (ram_en is sampled at the accept edge).
- Read latency: rspN_valid is high exactly 1 cycle after the accepting edge, for 1 cycle.
- Throughput: 1 beat/cycle sustained within a burst.
- Handover: zero bubble.
  - Last beat of requester A accepted at edge k → requester B can be accepted in cycle k+1 if valid.
  - Back-to-back single-beat requests from both requesters alternate 0,1,0,1 every cycle.
- Simultaneous valid in IDLE is resolved by prio only. No requester waits longer than one full burst of the other.
- rst asserted in the same cycle as a valid beat: the beat is not accepted and no RAM access occurs.

## Test plan
- Reset check: hold rst 2 cycles with both valids high → readies=0, ram_en=0, rsp valids=0. After release, with prio=0, req0 is granted first.
- Single read: req0 writes 0xDEADBEEF @0x010 (last=1), then reads @0x010 → rsp0_valid one cycle after accept with rdata 0xDEADBEEF. rsp1_valid stays 0.
- Burst lock: req0 issues a 4-beat write burst to 0x020..0x023 while req1 holds a read valid.
  - req1_ready=0 throughout req0's burst.
  - req1 is accepted the cycle after req0's last beat.
  - req1 read @0x022 returns req0's data.
- Round-robin fairness: both issue continuous single-beat reads for 10 cycles → grants alternate 0,1,0,…. Each requester gets 5 accepts and 5 responses with matching addresses.
- Burst gap: req1 starts a 3-beat read burst and drops valid for 2 cycles mid-burst while req0 is valid.
  - req0 stays blocked and ram_en=0 during the gap.
  - The burst completes and then req0 is granted.
- Reset mid-burst: assert rst after beat 2 of a 4-beat req0 burst → next cycle state IDLE, prio=0, pending response suppressed (rsp0_valid=0), req1 can be granted immediately after release if req0 is idle.
